// File: rtl/exec_pkg.sv
// Shared opcode encodings, flag bit positions and FSM states for the execution stage.
package exec_pkg;

  localparam int unsigned OP_ADD = 0;
  localparam int unsigned OP_SUB = 1;
  localparam int unsigned OP_AND = 2;
  localparam int unsigned OP_OR  = 3;
  localparam int unsigned OP_XOR = 4;
  localparam int unsigned OP_NOT = 5;
  localparam int unsigned OP_SHL = 6;
  localparam int unsigned OP_SHR = 7;
  localparam int unsigned OP_MOV = 8;
  localparam int unsigned OP_CMP = 9;
  localparam int unsigned OP_MUL = 10;

  localparam int unsigned FLAG_C = 3;
  localparam int unsigned FLAG_V = 2;
  localparam int unsigned FLAG_N = 1;
  localparam int unsigned FLAG_Z = 0;
  localparam int unsigned FLAG_W = 4;

  typedef enum logic {
    IDLE    = 1'b0,
    MUL_RUN = 1'b1
  } state_t;

endpackage

// File: rtl/seq_multiplier.sv
// Iterative unsigned shift-add multiplier: one partial-product step per cycle, WIDTH steps.
module seq_multiplier #(
  parameter int unsigned WIDTH = 8
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               start,
  input  logic               abort,
  input  logic [WIDTH-1:0]   a,
  input  logic [WIDTH-1:0]   b,
  output logic               done_c,
  output logic [2*WIDTH-1:0] product_c
);

  localparam int unsigned CW = $clog2(WIDTH + 1);

  logic [CW-1:0]      cnt;
  logic [WIDTH-1:0]   mcand;
  logic [2*WIDTH-1:0] prod;
  logic [WIDTH-1:0]   addend;
  logic [WIDTH:0]     hi_sum;

  // Upper half accumulates, lower half holds the remaining multiplier bits; shift right each step.
  always_comb begin
    addend    = prod[0] ? mcand : '0;
    hi_sum    = {1'b0, prod[2*WIDTH-1:WIDTH]} + {1'b0, addend};
    product_c = {hi_sum, prod[WIDTH-1:1]};
    done_c    = (cnt == CW'(1));
  end

  always_ff @(posedge clk) begin
    if (reset || abort) begin
      cnt   <= '0;
      mcand <= '0;
      prod  <= '0;
    end else if (start) begin
      cnt   <= CW'(WIDTH);
      mcand <= a;
      prod  <= {{WIDTH{1'b0}}, b};
    end else if (cnt != '0) begin
      cnt   <= cnt - CW'(1);
      prod  <= product_c;
    end
  end

endmodule

// File: rtl/exec_stage.sv
// Execution stage: single-cycle ALU plus iterative multiply, registered results under valid/ready.
module exec_stage
  import exec_pkg::*;
#(
  parameter int unsigned WIDTH = 8,
  parameter int unsigned OPW   = 5
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              flush,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [WIDTH-1:0]  A,
  input  logic [WIDTH-1:0]  B,
  input  logic [WIDTH-1:0]  data_in,
  input  logic [OPW-1:0]    op_dec,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [WIDTH-1:0]  ans_ex,
  output logic [FLAG_W-1:0] flag_ex,
  output logic [WIDTH-1:0]  DM_data,
  output logic [WIDTH-1:0]  data_out,
  output logic              busy
);

  localparam int unsigned MSB = WIDTH - 1;
  localparam int unsigned SHW = $clog2(WIDTH);

  state_t state, state_nxt;
  logic   accept, mul_start, mul_fin, is_mul;

  logic               mul_done_c;
  logic [2*WIDTH-1:0] mul_product_c;
  logic [WIDTH-1:0]   mul_lo, mul_hi;
  logic [WIDTH-1:0]   dm_pend, din_pend;

  logic [SHW-1:0]    shamt;
  logic [WIDTH:0]    sum_w, diff_w, shl_w, shr_w;
  logic [WIDTH-1:0]  alu_res, nz_src;
  logic [FLAG_W-1:0] alu_flags;
  logic              alu_upd, alu_c, alu_v;

  assign is_mul = (op_dec == OPW'(OP_MUL));
  assign shamt  = B[SHW-1:0];
  assign mul_lo = mul_product_c[WIDTH-1:0];
  assign mul_hi = mul_product_c[2*WIDTH-1:WIDTH];

  seq_multiplier #(.WIDTH(WIDTH)) u_mul (
    .clk       (clk),
    .reset     (reset),
    .start     (mul_start),
    .abort     (flush),
    .a         (A),
    .b         (B),
    .done_c    (mul_done_c),
    .product_c (mul_product_c)
  );

  always_ff @(posedge clk) begin
    if (reset) state <= IDLE;
    else       state <= state_nxt;
  end

  // Next state and handshake; a new input is taken only when the output slot is free or draining.
  always_comb begin
    state_nxt = state;
    in_ready  = 1'b0;
    accept    = 1'b0;
    mul_start = 1'b0;
    mul_fin   = 1'b0;
    case (state)
      IDLE: begin
        in_ready = (!out_valid || out_ready) && !reset && !flush;
        accept   = in_valid && in_ready;
        if (accept && is_mul) begin
          mul_start = 1'b1;
          state_nxt = MUL_RUN;
        end
      end
      MUL_RUN: begin
        if (mul_done_c) begin
          mul_fin   = !flush;
          state_nxt = IDLE;
        end
      end
      default: state_nxt = IDLE;
    endcase
    if (flush) state_nxt = IDLE;
  end

  // Combinational ALU; unknown opcodes pass A through and keep the current flags.
  always_comb begin
    sum_w     = {1'b0, A} + {1'b0, B};
    diff_w    = {1'b0, A} - {1'b0, B};
    shl_w     = {1'b0, A} << shamt;
    shr_w     = {A, 1'b0} >> shamt;
    alu_res   = A;
    nz_src    = A;
    alu_upd   = 1'b1;
    alu_c     = 1'b0;
    alu_v     = 1'b0;
    alu_flags = flag_ex;
    case (op_dec)
      OPW'(OP_ADD): begin
        alu_res = sum_w[WIDTH-1:0];
        alu_c   = sum_w[WIDTH];
        alu_v   = (A[MSB] == B[MSB]) && (sum_w[MSB] != A[MSB]);
      end
      OPW'(OP_SUB), OPW'(OP_CMP): begin
        alu_res = (op_dec == OPW'(OP_SUB)) ? diff_w[WIDTH-1:0] : A;
        alu_c   = diff_w[WIDTH];
        alu_v   = (A[MSB] != B[MSB]) && (diff_w[MSB] != A[MSB]);
      end
      OPW'(OP_AND): alu_res = A & B;
      OPW'(OP_OR):  alu_res = A | B;
      OPW'(OP_XOR): alu_res = A ^ B;
      OPW'(OP_NOT): alu_res = ~A;
      OPW'(OP_SHL): begin
        alu_res = shl_w[WIDTH-1:0];
        alu_c   = shl_w[WIDTH];
      end
      OPW'(OP_SHR): begin
        alu_res = shr_w[WIDTH:1];
        alu_c   = shr_w[0];
      end
      OPW'(OP_MOV): alu_res = B;
      default:      alu_upd = 1'b0;
    endcase
    nz_src = (op_dec == OPW'(OP_CMP)) ? diff_w[WIDTH-1:0] : alu_res;
    if (alu_upd) begin
      alu_flags[FLAG_C] = alu_c;
      alu_flags[FLAG_V] = alu_v;
      alu_flags[FLAG_N] = nz_src[MSB];
      alu_flags[FLAG_Z] = (nz_src == '0);
    end
  end

  // Output register; store/load data of a multiply wait in the pending regs until it completes.
  always_ff @(posedge clk) begin
    if (reset) begin
      out_valid <= 1'b0;
      busy      <= 1'b0;
      ans_ex    <= '0;
      flag_ex   <= '0;
      DM_data   <= '0;
      data_out  <= '0;
      dm_pend   <= '0;
      din_pend  <= '0;
    end else begin
      busy <= (state_nxt == MUL_RUN);
      if (flush) begin
        out_valid <= 1'b0;
      end else if (mul_fin) begin
        out_valid       <= 1'b1;
        ans_ex          <= mul_lo;
        flag_ex[FLAG_C] <= (mul_hi != '0);
        flag_ex[FLAG_V] <= 1'b0;
        flag_ex[FLAG_N] <= mul_lo[MSB];
        flag_ex[FLAG_Z] <= (mul_lo == '0);
        DM_data         <= dm_pend;
        data_out        <= din_pend;
      end else if (accept && !is_mul) begin
        out_valid <= 1'b1;
        ans_ex    <= alu_res;
        flag_ex   <= alu_flags;
        DM_data   <= B;
        data_out  <= data_in;
      end else if (out_valid && out_ready) begin
        out_valid <= 1'b0;
      end
      if (mul_start) begin
        dm_pend  <= B;
        din_pend <= data_in;
      end
    end
  end

endmodule

// File: tb/tb_exec_stage.sv
// Directed bench for exec_stage at WIDTH = 8 with hand-computed expectations.
module tb_exec_stage;

  localparam int unsigned W = 8;

  logic         clk = 1'b0;
  logic         reset, flush, in_valid, out_ready;
  logic         in_ready, out_valid, busy;
  logic [W-1:0] A, B, data_in, ans_ex, DM_data, data_out;
  logic [4:0]   op_dec;
  logic [3:0]   flag_ex;

  int errors = 0;
  int checks = 0;

  exec_stage #(.WIDTH(W), .OPW(5)) dut (
    .clk       (clk),
    .reset     (reset),
    .flush     (flush),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .A         (A),
    .B         (B),
    .data_in   (data_in),
    .op_dec    (op_dec),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .ans_ex    (ans_ex),
    .flag_ex   (flag_ex),
    .DM_data   (DM_data),
    .data_out  (data_out),
    .busy      (busy)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic drive(input logic [4:0] op, input logic [W-1:0] a, input logic [W-1:0] b,
                       input logic [W-1:0] d);
    in_valid = 1'b1;
    op_dec   = op;
    A        = a;
    B        = b;
    data_in  = d;
  endtask

  // Streaming vectors: op, A, B, expected result, expected flags {C,V,N,Z}
  logic [4:0]   s_op  [8] = '{5'd2, 5'd3, 5'd4, 5'd6, 5'd7, 5'd6, 5'd5, 5'd8};
  logic [W-1:0] s_a   [8] = '{8'hCC, 8'hCC, 8'hCC, 8'h81, 8'h81, 8'h81, 8'h0F, 8'h12};
  logic [W-1:0] s_b   [8] = '{8'hAA, 8'hAA, 8'hCC, 8'h01, 8'h01, 8'h00, 8'h33, 8'h00};
  logic [W-1:0] s_res [8] = '{8'h88, 8'hEE, 8'h00, 8'h02, 8'h40, 8'h81, 8'hF0, 8'h00};
  logic [3:0]   s_flg [8] = '{4'b0010, 4'b0010, 4'b0001, 4'b1000, 4'b1000, 4'b0010, 4'b0010, 4'b0001};

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    reset = 1'b1; flush = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
    A = '0; B = '0; data_in = '0; op_dec = '0;
    tick(); tick();
    chk("rst_out_valid", 32'(out_valid), 32'h0);
    chk("rst_ans", 32'(ans_ex), 32'h0);
    chk("rst_flag", 32'(flag_ex), 32'h0);
    chk("rst_in_ready", 32'(in_ready), 32'h0);
    reset = 1'b0;
    #1;
    chk("idle_in_ready", 32'(in_ready), 32'h1);

    // ADD overflow into the sign bit
    drive(5'd0, 8'h7F, 8'h01, 8'h5A);
    tick();
    chk("add_valid", 32'(out_valid), 32'h1);
    chk("add_ans", 32'(ans_ex), 32'h80);
    chk("add_flag", 32'(flag_ex), 32'b0110);
    chk("add_dm", 32'(DM_data), 32'h01);
    chk("add_dout", 32'(data_out), 32'h5A);
    // SUB borrow, accepted while ADD drains
    drive(5'd1, 8'h00, 8'h01, 8'h00);
    chk("sub_in_ready", 32'(in_ready), 32'h1);
    tick();
    in_valid = 1'b0;
    chk("sub_ans", 32'(ans_ex), 32'hFF);
    chk("sub_flag", 32'(flag_ex), 32'b1010);
    tick();
    chk("drain_valid", 32'(out_valid), 32'h0);

    // MUL 0x10 * 0x11 = 0x110
    drive(5'd10, 8'h10, 8'h11, 8'h33);
    tick();
    in_valid = 1'b0;
    for (int k = 0; k < 8; k++) begin
      chk($sformatf("mul_busy_%0d", k), 32'(busy), 32'h1);
      chk($sformatf("mul_in_ready_%0d", k), 32'(in_ready), 32'h0);
      chk($sformatf("mul_valid_%0d", k), 32'(out_valid), 32'h0);
      tick();
    end
    chk("mul_done_busy", 32'(busy), 32'h0);
    chk("mul_valid", 32'(out_valid), 32'h1);
    chk("mul_ans", 32'(ans_ex), 32'h10);
    chk("mul_flag", 32'(flag_ex), 32'b1000);
    chk("mul_dm", 32'(DM_data), 32'h11);
    chk("mul_dout", 32'(data_out), 32'h33);
    tick();
    chk("mul_drain", 32'(out_valid), 32'h0);

    // Back-pressure on ADD 3 + 4, XOR waiting behind it
    out_ready = 1'b0;
    drive(5'd0, 8'h03, 8'h04, 8'h00);
    tick();
    drive(5'd4, 8'hF0, 8'h0F, 8'h00);
    for (int k = 0; k < 3; k++) begin
      chk($sformatf("bp_in_ready_%0d", k), 32'(in_ready), 32'h0);
      chk($sformatf("bp_valid_%0d", k), 32'(out_valid), 32'h1);
      chk($sformatf("bp_ans_%0d", k), 32'(ans_ex), 32'h07);
      chk($sformatf("bp_flag_%0d", k), 32'(flag_ex), 32'b0000);
      tick();
    end
    out_ready = 1'b1;
    #1;
    chk("bp_release_ready", 32'(in_ready), 32'h1);
    tick();
    in_valid = 1'b0;
    chk("bp_xor_ans", 32'(ans_ex), 32'hFF);
    chk("bp_xor_flag", 32'(flag_ex), 32'b0010);
    tick();

    // Streaming single-cycle ops back to back
    for (int i = 0; i < 8; i++) begin
      drive(s_op[i], s_a[i], s_b[i], 8'(i));
      chk($sformatf("st_in_ready_%0d", i), 32'(in_ready), 32'h1);
      tick();
      chk($sformatf("st_valid_%0d", i), 32'(out_valid), 32'h1);
      chk($sformatf("st_ans_%0d", i), 32'(ans_ex), 32'(s_res[i]));
      chk($sformatf("st_flag_%0d", i), 32'(flag_ex), 32'(s_flg[i]));
      chk($sformatf("st_dm_%0d", i), 32'(DM_data), 32'(s_b[i]));
    end
    in_valid = 1'b0;
    tick();

    // Flush during the fourth cycle of a MUL
    drive(5'd10, 8'h03, 8'h05, 8'h00);
    tick();
    in_valid = 1'b0;
    tick(); tick(); tick();
    flush = 1'b1;
    #1;
    chk("fl_in_ready", 32'(in_ready), 32'h0);
    tick();
    flush = 1'b0;
    chk("fl_busy", 32'(busy), 32'h0);
    for (int k = 0; k < 8; k++) begin
      chk($sformatf("fl_valid_%0d", k), 32'(out_valid), 32'h0);
      tick();
    end
    chk("fl_flag_kept", 32'(flag_ex), 32'b0001);
    drive(5'd0, 8'h02, 8'h03, 8'h00);
    tick();
    in_valid = 1'b0;
    chk("fl_add_valid", 32'(out_valid), 32'h1);
    chk("fl_add_ans", 32'(ans_ex), 32'h05);
    chk("fl_add_flag", 32'(flag_ex), 32'b0000);
    tick();

    // Reset mid-MUL
    drive(5'd10, 8'h0F, 8'h0F, 8'h44);
    tick();
    in_valid = 1'b0;
    tick(); tick();
    reset = 1'b1;
    tick();
    reset = 1'b0;
    chk("rm_busy", 32'(busy), 32'h0);
    chk("rm_valid", 32'(out_valid), 32'h0);
    chk("rm_ans", 32'(ans_ex), 32'h0);
    for (int k = 0; k < 8; k++) begin
      chk($sformatf("rm_stale_%0d", k), 32'(out_valid), 32'h0);
      tick();
    end

    // Reset while a result is held by back-pressure
    out_ready = 1'b0;
    drive(5'd0, 8'h01, 8'h01, 8'h77);
    tick();
    in_valid = 1'b0;
    chk("rh_held", 32'(out_valid), 32'h1);
    reset = 1'b1;
    tick();
    reset = 1'b0;
    out_ready = 1'b1;
    chk("rh_valid", 32'(out_valid), 32'h0);
    chk("rh_ans", 32'(ans_ex), 32'h0);
    chk("rh_flag", 32'(flag_ex), 32'h0);
    chk("rh_dm", 32'(DM_data), 32'h0);
    chk("rh_dout", 32'(data_out), 32'h0);

    // CMP then NOP keeps flags
    drive(5'd9, 8'h05, 8'h05, 8'h00);
    tick();
    chk("cmp_ans", 32'(ans_ex), 32'h05);
    chk("cmp_flag", 32'(flag_ex), 32'b0001);
    drive(5'd15, 8'h42, 8'h10, 8'h00);
    tick();
    in_valid = 1'b0;
    chk("nop_ans", 32'(ans_ex), 32'h42);
    chk("nop_flag", 32'(flag_ex), 32'b0001);
    tick();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/exec_stage.md
# exec_stage

Parametrised execution stage for the MIPS-style datapath, successor to the fixed 8-bit ALU-plus-register execution block. Executes one operation per accepted instruction, registers the result, flags and store data, and presents them downstream under a valid/ready handshake so memory or write-back can stall it. Adds a multi-cycle iterative multiply, back-pressure and flush, none of which the single-cycle 8-bit block supports.

## Interface
- WIDTH, 8, datapath width; legal range 4..32
- OPW, 5, opcode width
- clk  in  1  clock; all state updates on the rising edge
- reset  in  1  synchronous, active-high; clears all state
- flush  in  1  synchronous abort of the in-flight operation and output
- in_valid  in  1  A, B, data_in and op_dec are valid
- in_ready  out  1  stage accepts this cycle
- A  in  WIDTH  operand A
- B  in  WIDTH  operand B; also store data
- data_in  in  WIDTH  load data, forwarded unchanged
- op_dec  in  OPW  decoded opcode
- out_valid  out  1  ans_ex, flag_ex, DM_data, data_out are valid
- out_ready  in  1  downstream consumes this cycle
- ans_ex  out  WIDTH  registered result
- flag_ex  out  4  registered flags {C, V, N, Z}
- DM_data  out  WIDTH  registered B of the same instruction
- data_out  out  WIDTH  registered data_in of the same instruction
- busy  out  1  multiply in progress

## Operation
- Opcodes: 0 ADD, 1 SUB (A−B), 2 AND, 3 OR, 4 XOR, 5 NOT A, 6 SHL A by B[log2 WIDTH−1:0], 7 SHR logical, same shift amount, 8 MOV B, 9 CMP (A−B, flags only, ans_ex = A), 10 MUL (low WIDTH bits of A×B, unsigned). All other codes: NOP, ans_ex = A, flags unchanged.
- Z = (result == 0); N = result MSB. ADD/SUB/CMP: C = carry out (SUB: borrow, i.e. A < B unsigned), V = signed overflow. Logic ops and MOV: C = V = 0. Shifts: C = last bit shifted out; C = 0 for a shift of 0; V = 0. MUL: C = (high WIDTH bits ≠ 0), V = 0. For CMP, Z and N come from A−B.
- FSM states: IDLE, MUL_RUN. IDLE plus MUL accepted → MUL_RUN and load counter = WIDTH. MUL_RUN: one shift-add per cycle; counter reaches 0 → result loaded and back to IDLE.
- Handshake: in_ready = (state == IDLE) && (!out_valid || out_ready) && !reset. Transfer occurs when in_valid && in_ready. Output transfer occurs when out_valid && out_ready.
- Outputs hold stable while out_valid && !out_ready.
- A simultaneous output transfer and input acceptance is allowed; this gives full throughput for single-cycle ops.
- flush: clears out_valid, returns the FSM to IDLE, discards a partial product, and leaves flag_ex unchanged. Any input presented in the same cycle is not accepted, because in_ready is forced 0.
- Reset: out_valid = 0, busy = 0, ans_ex = 0, flag_ex = 0, DM_data = 0, data_out = 0, state = IDLE. Reset has priority over flush. Reset mid-multiply aborts the multiply.

## Timing
- Single-cycle op accepted at edge t: out_valid high after edge t, with results valid in that cycle.
- MUL accepted at edge t: busy is high from t through t+WIDTH−1; results load at edge t+WIDTH; out_valid goes high after that edge. in_ready = 0 throughout.
- DM_data and data_out are captured at acceptance and presented with the result of the same instruction.
- No combinational path from in_valid to out_valid. in_ready depends combinationally on out_ready only.

## Structure
- Package exec_pkg holds the opcode constants, the flag bit indices (C = 3, V = 2, N = 1, Z = 0) and the FSM state enum.
- Sub-module seq_multiplier holds the iterative multiplier, with start/done, WIDTH parameter, 2·WIDTH product and its own counter.
- The combinational ALU and the output register live in exec_stage.

## Test plan
- WIDTH = 8, ADD 0x7F + 0x01 → ans_ex = 0x80, flag_ex = {C0, V1, N1, Z0}, one cycle after accept. SUB 0x00 − 0x01 → 0xFF, C = 1, N = 1.
- MUL 0x10 × 0x11 → after 8 cycles ans_ex = 0x10, C = 1 (product 0x110). busy is high for 8 cycles, and in_ready stays 0 throughout.
- Back-pressure: out_ready = 0 for 3 cycles after ADD 3 + 4 → ans_ex holds 0x07 and in_ready = 0. A following input is then accepted in the same cycle as the transfer.
- Streaming: AND, OR, XOR, SHL (0x81 by 1 → 0x02, C = 1) back-to-back with out_ready = 1 → one result per cycle in order, with DM_data = B of each.
- Flush at cycle 4 of a MUL → out_valid stays 0, busy drops next cycle, flag_ex keeps its prior value, and the next ADD completes normally.
- Reset asserted mid-MUL and while out_valid is held → all outputs 0 next cycle. CMP 5 vs 5 afterwards → Z = 1 and ans_ex = 0x05.
